// File: rtl/dll_pkg.sv
// dll_pkg: shared types and sequence-number helpers for the DLL replay buffer
package dll_pkg;
  localparam int SEQ_W = 12;
  typedef enum logic [0:0] {IDLE, REPLAY} rb_state_t;
  // a precedes or equals b in modular sequence space of width w
  function automatic logic seq_le(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return ((b - a) & m) < (32'd1 << (w - 1));
  endfunction
endpackage

// File: rtl/rb_sdp_ram.sv
// rb_sdp_ram: one synchronous write port, two combinational read ports
module rb_sdp_ram #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [W-1:0]  rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [W-1:0]  rdata_b_o
);
  logic [W-1:0] mem [DEPTH];
  // storage write, contents intentionally not reset
  always_ff @(posedge clk) if (we_i) mem[waddr_i] <= wdata_i;
  assign rdata_a_o = mem[raddr_a_i];
  assign rdata_b_o = mem[raddr_b_i];
endmodule

// File: rtl/dll_replay_buffer.sv
// dll_replay_buffer: holds sequenced TLPs until ACKed and replays them oldest first
module dll_replay_buffer import dll_pkg::*; #(
  parameter int DATA_W = 128,
  parameter int MAX_SEGS = 3,
  parameter int DEPTH = 256,
  parameter int SEQ_W = dll_pkg::SEQ_W,
  parameter int AF_MARGIN = 4,
  localparam int SW = $clog2(MAX_SEGS+1),
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW+1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATA_W*MAX_SEGS-1:0] wr_data,
  input  logic [SEQ_W-1:0]           wr_seq,
  input  logic [SW-1:0]              wr_nseg,
  input  logic                       ack_valid,
  input  logic [SEQ_W-1:0]           ack_seq,
  input  logic                       replay_req,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic [SEQ_W-1:0]           rd_seq,
  output logic                       rd_last,
  output logic                       replay_busy,
  output logic [CW-1:0]              count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       overflow
);
  localparam int DW = DATA_W*MAX_SEGS;
  localparam int EW = DW+SEQ_W+SW;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, rptr_q, rptr_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [CW-1:0] count_q, count_d;
  rb_state_t state_q, state_d;
  logic ack_pend_q, ack_pend_d;
  logic [SEQ_W-1:0] ack_lat_q, ack_lat_d;
  logic [EW-1:0] rd_ent, hd_ent;
  logic [DW-1:0] rd_shift;
  logic [SW-1:0] rd_nseg;
  logic [SEQ_W-1:0] hd_seq;
  logic idle, wr_fire, purge, rd_fire, beat_last, unused_hd;
  rb_sdp_ram #(.W(EW), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we_i(wr_fire), .waddr_i(tail_q), .wdata_i({wr_data, wr_seq, wr_nseg}),
    .raddr_a_i(rptr_q), .rdata_a_o(rd_ent), .raddr_b_i(head_q), .rdata_b_o(hd_ent)
  );
  assign unused_hd = ^{hd_ent[EW-1:SW+SEQ_W], hd_ent[SW-1:0]};
  assign hd_seq = hd_ent[SW +: SEQ_W];
  assign rd_nseg = rd_ent[SW-1:0];
  assign idle = state_q == IDLE;
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign almost_full = count_q >= CW'(DEPTH-AF_MARGIN);
  assign wr_ready = !full && idle;
  assign overflow = wr_valid && !wr_ready;
  assign wr_fire = wr_valid && wr_ready;
  assign replay_busy = !idle;
  assign rd_valid = !idle;
  assign rd_fire = rd_valid && rd_ready;
  assign rd_shift = rd_ent[EW-1:SEQ_W+SW] << (int'(seg_q)*DATA_W);
  assign beat_last = seg_q == rd_nseg - SW'(1);
  assign rd_data = rd_valid ? rd_shift[DW-1 -: DATA_W] : '0;
  assign rd_seq = rd_valid ? rd_ent[SW +: SEQ_W] : '0;
  assign rd_last = rd_valid && beat_last;
  // head retirement against the latched ACK; held off while replaying
  always_comb begin
    purge = idle && ack_pend_q && !empty && seq_le(32'(hd_seq), 32'(ack_lat_q), SEQ_W);
    head_d = head_q + AW'(purge);
    tail_d = tail_q + AW'(wr_fire);
    count_d = count_q + CW'(wr_fire) - CW'(purge);
    ack_lat_d = ack_valid ? ack_seq : ack_lat_q;
    ack_pend_d = ack_valid || (ack_pend_q && !(idle && !purge));
  end
  // replay FSM; replay starts at the post-purge head so retired TLPs are never resent
  always_comb begin
    state_d = state_q;
    rptr_d = rptr_q;
    seg_d = seg_q;
    if (idle) begin
      if (replay_req && count_d != '0) begin
        state_d = REPLAY;
        rptr_d = head_d;
        seg_d = '0;
      end
    end else if (rd_fire) begin
      seg_d = beat_last ? '0 : seg_q + SW'(1);
      rptr_d = beat_last ? rptr_q + AW'(1) : rptr_q;
      state_d = (beat_last && rptr_q + AW'(1) == tail_q) ? IDLE : REPLAY;
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      rptr_q <= '0;
      seg_q <= '0;
      count_q <= '0;
      state_q <= IDLE;
      ack_pend_q <= 1'b0;
      ack_lat_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      rptr_q <= rptr_d;
      seg_q <= seg_d;
      count_q <= count_d;
      state_q <= state_d;
      ack_pend_q <= ack_pend_d;
      ack_lat_q <= ack_lat_d;
    end
  end
endmodule

// File: tb/tb_dll_replay_buffer.sv
// tb_dll_replay_buffer: directed stimulus checked against a queue-based reference model
module tb_dll_replay_buffer;
  localparam int DEPTH = 256;
  logic clk = 0, rst = 1;
  logic wr_valid = 0, ack_valid = 0, replay_req = 0, rd_ready = 1;
  logic [383:0] wr_data = '0;
  logic [11:0] wr_seq = '0, ack_seq = '0;
  logic [1:0] wr_nseg = '0;
  logic wr_ready, rd_valid, rd_last, replay_busy, full, empty, almost_full, overflow;
  logic [127:0] rd_data;
  logic [11:0] rd_seq;
  logic [8:0] count;
  int nvec = 0, nerr = 0, nbeats = 0;
  bit en = 0;

  always #5 clk = ~clk;

  dll_replay_buffer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_seq(wr_seq), .wr_nseg(wr_nseg), .ack_valid(ack_valid), .ack_seq(ack_seq),
    .replay_req(replay_req), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_seq(rd_seq), .rd_last(rd_last), .replay_busy(replay_busy), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .overflow(overflow)
  );

  typedef struct { logic [383:0] data; logic [11:0] seq; int nseg; } ent_t;
  ent_t q[$];
  bit mbusy = 0, mpend = 0, was_busy, wf, pg;
  int mri = 0, mseg = 0;
  logic [11:0] mlat = '0;

  function automatic logic [383:0] mk(int s, int n);
    logic [383:0] d = '0;
    for (int b = 0; b < n; b++) d[(2-b)*128 +: 128] = {32'(s), 32'(b), 64'h0123_4567_89AB_CDEF ^ 64'(s*7+b)};
    return d;
  endfunction

  function automatic bit seqle(logic [11:0] a, logic [11:0] b);
    int d = (int'(b) - int'(a) + 4096) % 4096;
    return d < 2048;
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // reference model: a queue of stored TLPs plus a replay cursor (entry index, beat index)
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      mbusy = 0;
      mpend = 0;
      mri = 0;
      mseg = 0;
    end else begin
      was_busy = mbusy;
      wf = wr_valid && q.size() < DEPTH && !mbusy;
      pg = !mbusy && mpend && q.size() > 0 && seqle(q[0].seq, mlat);
      if (was_busy && rd_ready) begin
        if (mseg == q[mri].nseg - 1) begin
          mseg = 0;
          mri++;
          if (mri == q.size()) mbusy = 0;
        end else mseg++;
      end
      if (!was_busy) begin
        if (pg) void'(q.pop_front());
        if (wf) q.push_back('{data: wr_data, seq: wr_seq, nseg: int'(wr_nseg)});
        if (replay_req && q.size() > 0) begin
          mbusy = 1;
          mri = 0;
          mseg = 0;
        end
        if (!pg) mpend = 0;
      end
      if (ack_valid) begin
        mpend = 1;
        mlat = ack_seq;
      end
    end
  end

  // every-cycle comparison of DUT outputs against the model
  always @(negedge clk) if (en) begin
    chk("count", 128'(count), 128'(q.size()));
    chk("empty", 128'(empty), 128'(q.size() == 0));
    chk("full", 128'(full), 128'(q.size() == DEPTH));
    chk("almost_full", 128'(almost_full), 128'(q.size() >= DEPTH - 4));
    chk("wr_ready", 128'(wr_ready), 128'(q.size() < DEPTH && !mbusy));
    chk("overflow", 128'(overflow), 128'(wr_valid && !(q.size() < DEPTH && !mbusy)));
    chk("rd_valid", 128'(rd_valid), 128'(mbusy));
    chk("replay_busy", 128'(replay_busy), 128'(mbusy));
    if (mbusy) begin
      chk("rd_data", rd_data, q[mri].data[(2-mseg)*128 +: 128]);
      chk("rd_seq", 128'(rd_seq), 128'(q[mri].seq));
      chk("rd_last", 128'(rd_last), 128'(mseg == q[mri].nseg - 1));
    end
    if (rd_valid && rd_ready) nbeats++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int n);
    wr_valid = 1;
    wr_seq = 12'(s);
    wr_nseg = 2'(n);
    wr_data = mk(s, n);
    step();
    wr_valid = 0;
  endtask

  task automatic ack(input int s);
    ack_valid = 1;
    ack_seq = 12'(s);
    step();
    ack_valid = 0;
  endtask

  task automatic replay();
    replay_req = 1;
    step();
    replay_req = 0;
  endtask

  task automatic wait_idle(input int mx);
    for (int i = 0; i < mx && replay_busy; i++) step();
    chk("replay_done", 128'(replay_busy), 128'(0));
  endtask

  int b0;
  logic [11:0] exp_seq [4];
  logic exp_last [4];

  initial begin
    exp_seq = '{12'd5, 12'd5, 12'd5, 12'd6};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
    repeat (2) step();
    rst = 0;
    en = 1;
    @(negedge clk);
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_wr_ready", 128'(wr_ready), 128'(1));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    // purge by ACK, one entry per cycle
    wr(0, 3); wr(1, 1); wr(2, 2); wr(3, 3);
    ack(1);
    @(negedge clk);
    chk("t1_count_pre", 128'(count), 128'(4));
    step(); step();
    chk("t1_count", 128'(count), 128'(2));
    replay();
    @(negedge clk);
    chk("t1_head_seq", 128'(rd_seq), 128'(2));
    wait_idle(20);
    ack(3);
    repeat (3) step();
    chk("t1_empty", 128'(empty), 128'(1));
    // basic replay
    wr(5, 3); wr(6, 1);
    replay();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_rd_seq", 128'(rd_seq), 128'(exp_seq[i]));
      chk("t3_rd_last", 128'(rd_last), 128'(exp_last[i]));
      if (i == 0) chk("t3_rd_data0", rd_data, 128'({32'd5, 32'd0, 64'h0123_4567_89AB_CDEF ^ 64'd35}));
      step();
    end
    chk("t3_idle", 128'(replay_busy), 128'(0));
    // replay with backpressure
    rd_ready = 0;
    replay();
    b0 = nbeats;
    for (int i = 0; i < 20 && replay_busy; i++) begin
      rd_ready = (i % 3) != 1;
      step();
    end
    rd_ready = 1;
    chk("t4_idle", 128'(replay_busy), 128'(0));
    chk("t4_beats", 128'(nbeats - b0), 128'(4));
    ack(6);
    repeat (4) step();
    // sequence wrap
    wr(4094, 3); wr(4095, 1); wr(0, 2);
    ack(4093);
    repeat (3) step();
    chk("t5_nopurge", 128'(count), 128'(3));
    ack(0);
    repeat (4) step();
    chk("t5_empty", 128'(empty), 128'(1));
    // ACK during replay is deferred, then reset aborts a replay
    wr(10, 2); wr(11, 1); wr(12, 3);
    rd_ready = 0;
    replay();
    ack(11);
    step(); step();
    chk("t6_deferred", 128'(count), 128'(3));
    rd_ready = 1;
    wait_idle(20);
    repeat (3) step();
    chk("t6_purged", 128'(count), 128'(1));
    replay();
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("t6_rst_count", 128'(count), 128'(0));
    chk("t6_rst_rd_valid", 128'(rd_valid), 128'(0));
    // fill to full and overflow
    for (int i = 0; i < DEPTH; i++) wr(100 + i, 1 + i % 3);
    chk("t2_count", 128'(count), 128'(256));
    wr_valid = 1;
    @(negedge clk);
    chk("t2_overflow", 128'(overflow), 128'(1));
    chk("t2_full", 128'(full), 128'(1));
    chk("t2_wr_ready", 128'(wr_ready), 128'(0));
    step();
    wr_valid = 0;
    @(negedge clk);
    chk("t2_overflow_end", 128'(overflow), 128'(0));
    chk("t2_count_hold", 128'(count), 128'(256));
    replay();
    wait_idle(600);
    ack(355);
    for (int i = 0; i < 300 && !empty; i++) step();
    chk("t2_drained", 128'(empty), 128'(1));
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
